// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: FSM states and default widths.
// The optional cycle counter is enabled by defining PC_CYCLE_COUNT_EN.
package pc_ctrl_pkg;

  localparam int PC_PW_DEF = 10;
  localparam int PC_OW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bus between the instruction sequencer (master) and pc_ctrl (slave).
// CycleCnt exists only when PC_CYCLE_COUNT_EN is defined.
interface pc_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int PW = PC_PW_DEF,
  parameter int OW = PC_OW_DEF
);

  // Start is a one-cycle request taken on any unreset edge; there is no
  // ready back-pressure. Running/Ack/ProgCtr are registered level status.
  logic          Start;
  logic [PW-1:0] StartAddr;
  logic          BranchEn;
  logic          RelFlag;
  logic [OW-1:0] Offset;
  logic          Halt;
  logic          Stall;
  logic [PW-1:0] ProgCtr;
  logic          Running;
  logic          Ack;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0]   CycleCnt;
`endif

  modport master (
    output Start, StartAddr, BranchEn, RelFlag, Offset, Halt, Stall,
`ifdef PC_CYCLE_COUNT_EN
    input  CycleCnt,
`endif
    input  ProgCtr, Running, Ack
  );

  modport slave (
    input  Start, StartAddr, BranchEn, RelFlag, Offset, Halt, Stall,
`ifdef PC_CYCLE_COUNT_EN
    output CycleCnt,
`endif
    output ProgCtr, Running, Ack
  );

endinterface

// File: rtl/pc_next.sv
// Combinational next-address select: reload, hold, relative branch or increment.
// All arithmetic wraps modulo 2^PW.
module pc_next
  import pc_ctrl_pkg::*;
#(
  parameter int PW = PC_PW_DEF,
  parameter int OW = PC_OW_DEF
) (
  input  logic [PW-1:0] pc,
  input  logic [PW-1:0] start_addr,
  input  logic [OW-1:0] offset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          rel_flag,
  output logic [PW-1:0] next_pc
);

  logic [PW+OW-1:0] off_wide;
  logic [PW-1:0]    off_ext;

  always_comb begin
    // Over-extend then truncate so any PW/OW ratio sign-extends correctly.
    off_wide = {{PW{offset[OW-1]}}, offset};
    off_ext  = off_wide[PW-1:0];
    next_pc  = pc + PW'(1);
    if (start) begin
      next_pc = start_addr;
    end else if (stall || halt) begin
      next_pc = pc;
    end else if (branch_en && rel_flag) begin
      next_pc = pc + off_ext;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/DONE FSM plus the ProgCtr register.
// PC_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter (CycleCnt).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PW = PC_PW_DEF,
  parameter int OW = PC_OW_DEF
) (
  input  logic      Clk,
  input  logic      Reset,
  pc_ctrl_if.slave  bus,
  output pc_state_t state_dbg
);

  pc_state_t     state_q;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] next_pc;
  logic          running_q;
  logic          ack_q;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0]   cnt_q;
`endif

  pc_next #(.PW(PW), .OW(OW)) u_next (
    .pc         (pc_q),
    .start_addr (bus.StartAddr),
    .offset     (bus.Offset),
    .start      (bus.Start),
    .stall      (bus.Stall),
    .halt       (bus.Halt),
    .branch_en  (bus.BranchEn),
    .rel_flag   (bus.RelFlag),
    .next_pc    (next_pc)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
`ifdef PC_CYCLE_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Branch/halt/stall inputs are don't-care outside RUN.
          if (bus.Start) begin
            state_q   <= RUN;
            pc_q      <= next_pc;
            running_q <= 1'b1;
            ack_q     <= 1'b0;
`ifdef PC_CYCLE_COUNT_EN
            cnt_q     <= '0;
`endif
          end
        end
        RUN: begin
          pc_q <= next_pc;
`ifdef PC_CYCLE_COUNT_EN
          if (bus.Start) begin
            cnt_q <= '0;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
          if (!bus.Start && !bus.Stall && bus.Halt) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            ack_q     <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          ack_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Running = running_q;
  assign bus.Ack     = ack_q;
`ifdef PC_CYCLE_COUNT_EN
  assign bus.CycleCnt = cnt_q;
`endif
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed plus randomised bench for pc_ctrl with a reference model feeding an expected queue.
// Cycle-counter checks are active when PC_CYCLE_COUNT_EN is defined.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int PW = 10;
  localparam int OW = 8;
  localparam int W  = PW + 2 + 16;

  logic      Clk;
  logic      Reset;
  pc_state_t state_dbg;

  pc_ctrl_if #(.PW(PW), .OW(OW)) bus ();

  pc_ctrl #(.PW(PW), .OW(OW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  pc_state_t     m_state = IDLE;
  logic [PW-1:0] m_pc    = '0;
  logic [15:0]   m_cnt   = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [PW-1:0] a,
                            input logic be, input logic rf, input logic [OW-1:0] off,
                            input logic h, input logic sl);
    logic [PW-1:0] ext;
    ext = PW'(signed'(off));
    if (!rst) begin
      m_state = IDLE; m_pc = '0; m_cnt = '0;
    end else if (m_state == RUN) begin
      if (st) begin
        m_pc = a; m_cnt = '0;
      end else begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (sl) begin
        end else if (h) m_state = DONE;
        else if (be && rf) m_pc = m_pc + ext;
        else m_pc = m_pc + 10'd1;
      end
    end else if (st) begin
      m_state = RUN; m_pc = a; m_cnt = '0;
    end
  endtask

  function automatic logic [15:0] obs_cnt();
`ifdef PC_CYCLE_COUNT_EN
    return bus.CycleCnt;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef PC_CYCLE_COUNT_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  // driver: apply one cycle of inputs, predict, then compare one edge later
  task automatic step(input logic rst, input logic st, input logic [PW-1:0] a,
                      input logic be, input logic rf, input logic [OW-1:0] off,
                      input logic h, input logic sl);
    logic [W-1:0] got;
    Reset = rst; bus.Start = st; bus.StartAddr = a; bus.BranchEn = be;
    bus.RelFlag = rf; bus.Offset = off; bus.Halt = h; bus.Stall = sl;
    model_edge(rst, st, a, be, rf, off, h, sl);
    exp_q.push_back({m_state == DONE, m_state == RUN, m_pc, exp_cnt()});
    @(posedge Clk);
    #1;
    got = {bus.Ack, bus.Running, bus.ProgCtr, obs_cnt()};
    check("step_ack_run_pc_cnt", got, exp_q.pop_front());
    check("step_state", W'(state_dbg), W'(m_state));
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; bus.Start = 1'b0; bus.StartAddr = '0; bus.BranchEn = 1'b0;
    bus.RelFlag = 1'b0; bus.Offset = '0; bus.Halt = 1'b0; bus.Stall = 1'b0;

    // reset for two cycles
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'd77, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
    check("reset_pc", W'(bus.ProgCtr), W'(0));
    check("reset_flags", W'({bus.Running, bus.Ack}), W'(0));

    // start at 5, three plain cycles
    step(1'b1, 1'b1, 10'd5, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("start_pc", W'(bus.ProgCtr), W'(5));
    check("start_running", W'(bus.Running), W'(1));
    repeat (3) idle_step();
    check("run3_pc", W'(bus.ProgCtr), W'(8));

    // taken and not-taken branch from 20
    step(1'b1, 1'b1, 10'd20, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0);
    check("branch_taken", W'(bus.ProgCtr), W'(16));
    step(1'b1, 1'b1, 10'd20, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b0);
    check("branch_not_taken", W'(bus.ProgCtr), W'(21));

    // wrap-around both directions
    step(1'b1, 1'b1, 10'd1023, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle_step();
    check("wrap_up", W'(bus.ProgCtr), W'(0));
    step(1'b1, 1'b1, 10'd2, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
    check("wrap_down", W'(bus.ProgCtr), W'(898));

    // stall beats halt and branch; then halt lands in DONE
    repeat (2) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1);
    check("stall_hold_pc", W'(bus.ProgCtr), W'(898));
    check("stall_state", W'(state_dbg), W'(RUN));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("halt_flags", W'({bus.Ack, bus.Running}), W'(2'b10));

    // DONE ignores everything but Start
    repeat (2) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
    check("done_ignore_pc", W'(bus.ProgCtr), W'(898));

    // restart from DONE at 100, 7 cycles then halt
    step(1'b1, 1'b1, 10'd100, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("restart_pc", W'(bus.ProgCtr), W'(100));
    check("restart_ack", W'(bus.Ack), W'(0));
    repeat (7) idle_step();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
`ifdef PC_CYCLE_COUNT_EN
    check("cnt_done", W'(bus.CycleCnt), W'(8));
`endif
    repeat (3) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
`ifdef PC_CYCLE_COUNT_EN
    check("cnt_stable", W'(bus.CycleCnt), W'(8));
`endif

    // restart inside RUN, then reset mid-run
    step(1'b1, 1'b1, 10'd300, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) idle_step();
    step(1'b1, 1'b1, 10'd400, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0);
    check("restart_in_run", W'(bus.ProgCtr), W'(400));
    idle_step();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    check("midrun_reset_state", W'(state_dbg), W'(IDLE));
    check("midrun_reset_pc", W'(bus.ProgCtr), W'(0));
    repeat (2) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1);

    // randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 40) != 0, $urandom_range(0, 15) == 0,
           PW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), OW'($urandom_range(0, 255)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter PW, default 10: program counter width in bits.
REQ-002 Parameter OW, default 8: branch offset width in bits; the offset is signed two's complement.
REQ-003 Port Clk, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 Port Reset, input, 1: synchronous, active-low reset.
REQ-005 Port Start, input, 1: request to begin a program run from StartAddr.
REQ-006 Port StartAddr, input, PW: first instruction address for a run.
REQ-007 Port BranchEn, input, 1: the current instruction is a relative branch.
REQ-008 Port RelFlag, input, 1: branch-condition result from the ALU.
REQ-009 Port Offset, input, OW: signed branch displacement, taken from the branch LUT.
REQ-010 Port Halt, input, 1: the current instruction is a halt/done.
REQ-011 Port Stall, input, 1: hold the current instruction for one more cycle.
REQ-012 Port ProgCtr, output, PW: the current instruction address.
REQ-013 Port Running, output, 1: the controller is in the RUN state.
REQ-014 Port Ack, output, 1: the program has finished; this is the DONE state.

Function
REQ-015 The block SHALL implement three states, IDLE, RUN and DONE, encoded as a package enum.
- IDLE -> RUN when Start=1; on the same edge, ProgCtr <= StartAddr.
- DONE -> RUN when Start=1; on the same edge, ProgCtr <= StartAddr.
- RUN -> DONE when Halt=1 and Stall=0; ProgCtr holds its value.
- Every other case holds the current state.
REQ-016 In RUN, exactly one ProgCtr update SHALL occur per edge, with this priority: Start (reload StartAddr), then Stall (hold), then Halt (hold and go to DONE), then BranchEn&&RelFlag (ProgCtr + sign_ext(Offset)), otherwise ProgCtr + 1.
REQ-017 Start asserted while in RUN SHALL restart the run: ProgCtr <= StartAddr and the state stays RUN.
REQ-018 All ProgCtr arithmetic SHALL be modulo 2^PW.
- Wrap example: ProgCtr = 2^PW-1 with no branch gives 0 next.
- Wrap example: ProgCtr = 0 with Offset = -1 gives 2^PW-1 next.
REQ-019 BranchEn=1 with RelFlag=0 SHALL advance ProgCtr by +1, the same as a non-branch instruction.
REQ-020 BranchEn, RelFlag, Offset, Halt and Stall SHALL be ignored in IDLE and in DONE.
REQ-021 Running SHALL be 1 only in RUN, and Ack SHALL be 1 only in DONE; both are registered, with no combinational path from any input.
REQ-022 A taken branch SHALL take effect on the next edge, giving 1-cycle latency from the inputs to ProgCtr.

Reset
REQ-023 When Reset=0 at a rising edge, the block SHALL set state=IDLE, ProgCtr=0, Running=0, Ack=0 and (if compiled in) CycleCnt=0, overriding every other input.
REQ-024 A reset asserted mid-RUN SHALL abandon the run; there is no resume.

Configuration
REQ-025 When macro PC_CYCLE_COUNT_EN is defined, the block SHALL add output CycleCnt, 16 bits, holding the number of RUN cycles (stalled cycles included).
- CycleCnt clears to 0 on every Start edge.
- CycleCnt increments on every edge spent in RUN, saturating at 16'hFFFF.
- CycleCnt holds its value in DONE.
REQ-026 When PC_CYCLE_COUNT_EN is undefined, the CycleCnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 The shared definitions package SHALL hold the pc_state_t enum (IDLE, RUN, DONE) and the default PW and OW constants.
REQ-028 Next-address computation SHALL live in one combinational sub-module, pc_next, taking the current PC, StartAddr, Offset and the select inputs and producing the next PC; pc_ctrl SHALL hold only the registers and the FSM.

Verification
REQ-029 Reset then run: Reset=0 for 2 cycles, then StartAddr=10'd5 and a 1-cycle Start pulse -> ProgCtr=5, Running=1; 3 idle cycles -> ProgCtr=8.
REQ-030 Branch, taken and not taken:
- At ProgCtr=20, BranchEn=1, RelFlag=1, Offset=8'hFC (-4) -> next ProgCtr=16.
- Same inputs with RelFlag=0 -> next ProgCtr=21.
REQ-031 Wrap-around with PW=10:
- ProgCtr=1023, no branch -> 0.
- ProgCtr=2, Offset=8'h80 (-128) -> 898.
REQ-032 Stall priority: Stall=1 together with Halt=1 and a taken branch for 2 cycles -> ProgCtr unchanged and state RUN; drop Stall with Halt=1 -> Ack=1 and Running=0 the next cycle.
REQ-033 Restart and mid-run reset:
- In DONE, Start with StartAddr=100 -> Ack=0, ProgCtr=100.
- Reset=0 mid-RUN -> IDLE, ProgCtr=0, and with PC_CYCLE_COUNT_EN defined, CycleCnt=0.
REQ-034 Cycle counter (PC_CYCLE_COUNT_EN defined): a run of 7 cycles followed by Halt -> CycleCnt=8 in DONE and stable until the next Start.
